// File: rtl/sys_cmd_master_if.sv
// Host command, UART byte-TX and UART byte-RX signals of the command initiator.
// master = the initiator itself, slave = the host/UART side driving its inputs.
interface sys_cmd_master_if #(
  parameter int Data_width    = 8,
  parameter int Address_width = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_type;
  logic [Address_width-1:0] cmd_addr;
  logic [Data_width-1:0]    cmd_data;
  logic [Data_width-1:0]    cmd_opA;
  logic [Data_width-1:0]    cmd_opB;
  logic [3:0]               cmd_fun;
  logic [Data_width-1:0]    tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [Data_width-1:0]    rx_p_data;
  logic                     rx_d_valid;
  logic                     done;
  logic [Data_width-1:0]    rsp_data;
  logic                     timeout;

  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_opA, cmd_opB, cmd_fun,
    input  tx_ready, rx_p_data, rx_d_valid,
    output cmd_ready, tx_data, tx_valid, done, rsp_data, timeout
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_opA, cmd_opB, cmd_fun,
    output tx_ready, rx_p_data, rx_d_valid,
    input  cmd_ready, tx_data, tx_valid, done, rsp_data, timeout
  );
endinterface

// File: rtl/sys_cmd_master.sv
// Serializes one host command into an AA/BB/CC/DD byte frame and waits for the reply byte.
// Back-to-back frame bytes while tx_ready=1; tx_data held while stalled; reply-to-done 1 cycle.
module sys_cmd_master #(
  parameter int Data_width    = 8,
  parameter int Address_width = 4,
  parameter int TIMEOUT       = 4096
) (
  input logic              CLK,
  input logic              RST,
  sys_cmd_master_if.master bus
);
  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t                       state_q;
  logic [3:0][Data_width-1:0]   frame_q, frame_d;
  logic [2:0]                   len_q, len_d;
  logic [1:0]                   idx_q;
  logic                         rsp_exp_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [Data_width-1:0]        tx_data_q;
  logic                         tx_valid_q;
  logic                         done_q;
  logic [Data_width-1:0]        rsp_data_q;
  logic                         timeout_q;
  logic                         last_byte;

  always_comb begin
    frame_d = '0;
    len_d   = 3'd0;
    case (bus.cmd_type)
      2'd0: begin
        frame_d[0] = Data_width'(8'hAA);
        frame_d[1] = Data_width'(bus.cmd_addr);
        frame_d[2] = bus.cmd_data;
        len_d      = 3'd3;
      end
      2'd1: begin
        frame_d[0] = Data_width'(8'hBB);
        frame_d[1] = Data_width'(bus.cmd_addr);
        len_d      = 3'd2;
      end
      2'd2: begin
        frame_d[0] = Data_width'(8'hCC);
        frame_d[1] = bus.cmd_opA;
        frame_d[2] = bus.cmd_opB;
        frame_d[3] = Data_width'(bus.cmd_fun);
        len_d      = 3'd4;
      end
      default: begin
        frame_d[0] = Data_width'(8'hDD);
        frame_d[1] = Data_width'(bus.cmd_fun);
        len_d      = 3'd2;
      end
    endcase
  end

  assign last_byte = (({1'b0, idx_q} + 3'd1) == len_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      len_q      <= 3'd0;
      idx_q      <= 2'd0;
      rsp_exp_q  <= 1'b0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      rsp_data_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            frame_q    <= frame_d;
            len_q      <= len_d;
            idx_q      <= 2'd0;
            rsp_exp_q  <= (bus.cmd_type != 2'd0);
            tx_data_q  <= frame_d[0];
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.tx_ready) begin
            if (last_byte) begin
              tx_valid_q <= 1'b0;
              if (rsp_exp_q) begin
                cnt_q   <= '0;
                state_q <= S_WAIT;
              end else begin
                done_q    <= 1'b1;
                timeout_q <= 1'b0;
                state_q   <= S_IDLE;
              end
            end else begin
              idx_q     <= idx_q + 2'd1;
              tx_data_q <= frame_q[idx_q + 2'd1];
            end
          end
        end
        S_WAIT: begin
          // A reply landing on the terminal count still counts as a reply.
          if (bus.rx_d_valid) begin
            done_q     <= 1'b1;
            rsp_data_q <= bus.rx_p_data;
            timeout_q  <= 1'b0;
            state_q    <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            done_q     <= 1'b1;
            rsp_data_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.done      = done_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.timeout   = timeout_q;
endmodule
